// File: rtl/dac_update_sequencer.sv
// Multi-channel DAC update engine: snapshots all channel samples on a rate tick,
// shifts one SPI mode-0 frame per channel, then pulses LDAC low to update them together.
module dac_update_sequencer #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned SCLK_HALF   = 2,
  parameter int unsigned LDAC_CYCLES = 2
) (
  input  logic                           i_clk,
  input  logic                           i_arst_n,
  input  logic                           i_enable,
  input  logic [15:0]                    i_rate_div,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  output logic                           o_sample_req,
  output logic                           o_busy,
  output logic                           o_overrun,
  output logic                           o_dac_cs_n,
  output logic                           o_dac_sclk,
  output logic                           o_dac_sdo,
  output logic                           o_dac_ldac_n
);

  localparam int unsigned FW      = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PH_W    = $clog2(2 * FW + 1);
  localparam int unsigned CNT_MAX = (SCLK_HALF > LDAC_CYCLES) ? SCLK_HALF : LDAC_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SD_W    = CHANNELS * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2,
    LDAC  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [CH_W-1:0]   ch, ch_d;
  logic [PH_W-1:0]   phase, phase_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [15:0]       rate_cnt;
  logic [SD_W-1:0]   snap;
  logic              wrap_c;
  logic [FW-1:0]     word_c;
  logic [FW-1:0]     word_sh_c;
  logic [PH_W-1:0]   bidx_c;
  logic              sclk_d, sdo_d;

  // Update-rate counter; wrap_c marks the cycle before the counter returns to 0 (tick cycle)
  assign wrap_c = i_enable && (i_rate_div != 16'd0) && (rate_cnt >= (i_rate_div - 16'd1));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rate_cnt <= 16'd0;
    end else if (!i_enable || (i_rate_div == 16'd0) || wrap_c) begin
      rate_cnt <= 16'd0;
    end else begin
      rate_cnt <= rate_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      ch    <= '0;
      phase <= '0;
      cnt   <= '0;
      snap  <= '0;
    end else begin
      state <= state_d;
      ch    <= ch_d;
      phase <= phase_d;
      cnt   <= cnt_d;
      if ((state == IDLE) && o_sample_req) begin
        snap <= i_data;
      end
    end
  end

  always_comb begin
    state_d   = state;
    ch_d      = ch;
    phase_d   = phase;
    cnt_d     = cnt;
    sclk_d    = 1'b0;
    sdo_d     = 1'b0;
    word_c    = '0;
    word_sh_c = '0;
    bidx_c    = '0;

    unique case (state)
      IDLE: begin
        if (o_sample_req) begin
          state_d = FRAME;
          ch_d    = '0;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      FRAME: begin
        if (cnt == CNT_W'(SCLK_HALF - 1)) begin
          cnt_d = '0;
          if (phase == PH_W'(2 * FW)) begin
            state_d = GAP;
          end else begin
            phase_d = phase + PH_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(SCLK_HALF - 1)) begin
          cnt_d = '0;
          if (ch == CH_W'(CHANNELS - 1)) begin
            state_d = LDAC;
          end else begin
            state_d = FRAME;
            ch_d    = ch + CH_W'(1);
            phase_d = '0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LDAC: begin
        if (cnt == CNT_W'(LDAC_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // SCLK is high on odd half-periods; data bit index advances on each falling edge, holding the last bit
    if (state_d == FRAME) begin
      word_c = FW'(snap[ch_d*DATA_WIDTH +: DATA_WIDTH]) | (FW'(ch_d) << DATA_WIDTH);
      bidx_c = phase_d >> 1;
      if (bidx_c > PH_W'(FW - 1)) begin
        bidx_c = PH_W'(FW - 1);
      end
      word_sh_c = word_c << bidx_c;
      sdo_d     = word_sh_c[FW-1];
      sclk_d    = phase_d[0];
    end
  end

  // Registered pin and status outputs, all derived from the next-cycle state
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_sample_req <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
      o_dac_cs_n   <= 1'b1;
      o_dac_sclk   <= 1'b0;
      o_dac_sdo    <= 1'b0;
      o_dac_ldac_n <= 1'b1;
    end else begin
      o_sample_req <= wrap_c && (state_d == IDLE);
      o_overrun    <= wrap_c && (state_d != IDLE);
      o_busy       <= (state_d != IDLE);
      o_dac_cs_n   <= (state_d != FRAME);
      o_dac_sclk   <= sclk_d;
      o_dac_sdo    <= sdo_d;
      o_dac_ldac_n <= (state_d != LDAC);
    end
  end

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Directed bench for dac_update_sequencer with default parameters (2 ch, 14-bit frames, H=2).
module tb_dac_update_sequencer;

  logic        clk;
  logic        arst_n;
  logic        enable;
  logic [15:0] rate_div;
  logic [23:0] data;
  logic        sample_req, busy, overrun, cs_n, sclk, sdo, ldac_n;

  int checks   = 0;
  int failures = 0;

  logic [13:0] frm [2];
  int          csl [2];
  int          rises [2];
  int          gap, ldst, ldlen, bsy, ovr, reqs;
  logic [23:0] snap_exp;
  int          n;
  int          acc;

  dac_update_sequencer dut (
    .i_clk        (clk),
    .i_arst_n     (arst_n),
    .i_enable     (enable),
    .i_rate_div   (rate_div),
    .i_data       (data),
    .o_sample_req (sample_req),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_dac_cs_n   (cs_n),
    .o_dac_sclk   (sclk),
    .o_dac_sdo    (sdo),
    .o_dac_ldac_n (ldac_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until sample_req is seen; n = -1 if the bound expires
  task automatic wait_req(input int limit, input bit scramble, output int cyc);
    bit found = 1'b0;
    cyc = 0;
    while (!found && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (sample_req) found = 1'b1;
      else if (scramble) data = 24'($urandom);
    end
    if (!found) cyc = -1;
  endtask

  // Records one sequence starting from the negedge where sample_req was seen
  task automatic capture(input int ncyc, input bit scramble, input int drop_at);
    int   fidx = -1;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    snap_exp = data;
    frm[0] = '0; frm[1] = '0; csl[0] = 0; csl[1] = 0; rises[0] = 0; rises[1] = 0;
    gap = 0; ldst = -1; ldlen = 0; bsy = 0; ovr = 0; reqs = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (prev_cs && !cs_n) fidx++;
      if (!cs_n && fidx >= 0 && fidx < 2) begin
        csl[fidx]++;
        if (sclk && !prev_sclk) begin
          frm[fidx] = {frm[fidx][12:0], sdo};
          rises[fidx]++;
        end
      end
      if (cs_n && fidx == 0) gap++;
      if (!ldac_n) begin
        if (ldst < 0) ldst = c;
        ldlen++;
      end
      bsy  += int'(busy);
      ovr  += int'(overrun);
      reqs += int'(sample_req);
      prev_cs   = cs_n;
      prev_sclk = sclk;
      if (scramble) data = 24'($urandom);
      if (c == drop_at) enable = 1'b0;
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_frame0"}, 32'(frm[0]), 32'({2'b00, snap_exp[11:0]}));
    check({tag, "_frame1"}, 32'(frm[1]), 32'({2'b01, snap_exp[23:12]}));
    check({tag, "_ldac_start"}, 32'(ldst), 32'd121);
    check({tag, "_busy_len"}, 32'(bsy), 32'd122);
  endtask

  initial begin
    // Reset held with ticks enabled
    arst_n   = 1'b0;
    enable   = 1'b1;
    rate_div = 16'd10;
    data     = 24'h0;
    acc      = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      acc += int'(sample_req);
    end
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_ldac_n", 32'(ldac_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_no_req", 32'(acc), 32'd0);

    // Basic sequence at rate_div=200
    rate_div = 16'd200;
    data     = {12'h3FF, 12'hA5C};
    arst_n   = 1'b1;
    wait_req(1000, 1'b0, n);
    check("t2_first_tick", 32'(n), 32'd200);
    capture(130, 1'b0, -1);
    check("t2_frame0", 32'(frm[0]), 32'h0A5C);
    check("t2_frame1", 32'(frm[1]), 32'h13FF);
    check("t2_cs_low0", 32'(csl[0]), 32'd58);
    check("t2_cs_low1", 32'(csl[1]), 32'd58);
    check("t2_rises0", 32'(rises[0]), 32'd14);
    check("t2_gap", 32'(gap), 32'd2);
    check("t2_ldac_start", 32'(ldst), 32'd121);
    check("t2_ldac_len", 32'(ldlen), 32'd2);
    check("t2_busy_len", 32'(bsy), 32'd122);
    check("t2_overrun", 32'(ovr), 32'd0);

    // rate_div=100: every second tick is an overrun
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rate_div = 16'd100;
    enable   = 1'b1;
    wait_req(500, 1'b0, n);
    check("t3_first_tick", 32'(n), 32'd100);
    capture(199, 1'b0, -1);
    check_frames("t3");
    check("t3_overrun", 32'(ovr), 32'd1);
    check("t3_no_extra_req", 32'(reqs), 32'd0);
    @(negedge clk);
    check("t3_req_period", 32'(sample_req), 32'd1);

    // Input data scrambled every cycle after the snapshot
    capture(199, 1'b1, -1);
    check_frames("t4a");
    @(negedge clk);
    check("t4_req_period", 32'(sample_req), 32'd1);
    capture(199, 1'b1, -1);
    check_frames("t4b");
    @(negedge clk);
    check("t5_req_start", 32'(sample_req), 32'd1);

    // Enable dropped mid frame1: sequence completes, no further requests
    capture(300, 1'b0, 70);
    check_frames("t5");
    check("t5_ldac_len", 32'(ldlen), 32'd2);
    check("t5_no_req", 32'(reqs), 32'd0);
    enable = 1'b1;
    wait_req(500, 1'b0, n);
    check("t5_restart", 32'(n), 32'd100);

    // Async reset during frame0 bit 5
    repeat (23) @(negedge clk);
    check("t6_mid_cs", 32'(cs_n), 32'd0);
    check("t6_mid_sclk", 32'(sclk), 32'd1);
    arst_n = 1'b0;
    #1;
    check("t6_async_cs", 32'(cs_n), 32'd1);
    check("t6_async_sclk", 32'(sclk), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acc += int'(!ldac_n);
    end
    check("t6_no_ldac", 32'(acc), 32'd0);
    arst_n = 1'b1;
    data   = {12'h5A1, 12'h0C3};
    wait_req(500, 1'b0, n);
    check("t6_restart", 32'(n), 32'd100);
    capture(130, 1'b0, -1);
    check_frames("t6");

    // rate_div=1: tick every cycle, all ticks during busy are overruns
    rate_div = 16'd1;
    wait_req(10, 1'b0, n);
    check("t7_found", 32'(n > 0), 32'd1);
    capture(122, 1'b0, -1);
    check("t7_overruns", 32'(ovr), 32'd122);
    check("t7_frame0", 32'(frm[0]), 32'({2'b00, snap_exp[11:0]}));
    @(negedge clk);
    check("t7_req_next", 32'(sample_req), 32'd1);
    enable = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
